pb200_sequencer: RTL and testbench
==================================

// Module: pb200_sequencer
// PURPOSE
//   Control and state-storage end of the 2nd-order IIR (pb200) datapath. Per input sample it
//   steps the shared multiply-accumulate through five products by driving the coefficient,
//   state and addend selects (controlS/controlC/controlZ) of the pb200 select mux. It
//   registers each MAC result into the fk/acum/yk registers that feed back into that mux.
//   Recurrences: fk = Uk + a1*fk1 + a2*fk2 ; yk = b0*fk + b1*fk1 + b2*fk2.
// PARAMETERS
//   W     `N   data word width (signed fixed point, `F fraction bits), from constantes.h
// PORTS
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   start      in   1   sample strobe; accepted only when ready=1
//   uk_in      in   W   new input sample, captured on accepted start
//   sum        in   W   MAC result: ((muxS*muxC)>>>`F) + muxZ, combinational from this cycle's selects
//   ready      out  1   1 in IDLE only
//   done       out  1   one-cycle pulse: yk holds the new output
//   controlS   out  3   coefficient select: 0 zero, 1 a1, 2 a2, 3 b0, 4 b1, 5 b2
//   controlC   out  2   state select: 0 zero, 1 fk1, 2 fk2, 3 fk
//   controlZ   out  3   addend select: 0 zero, 1 Uk, 2 yk, 3 acum1, 4 acum2, 5 acum3
//   Uk,fk,fk1,fk2,acum1,acum2,acum3,yk  out  W  registered operands/results to the mux and system
//   clr_state  in   1   (PB200_CLR_EN only) synchronous filter-history clear
// BEHAVIOUR
//   - Reset: state IDLE. All W-bit registers 0. done=0, ready=1, all selects 0. Reset mid-sample
//     aborts it; no done is issued.
//   - FSM, one cycle per state. Selects are a combinational decode of the state only.
//     The register write in the "write" column happens at the end of that cycle.
//     state  S  C  Z  write
//     IDLE   0  0  0  on start: Uk<=uk_in, ->MAC1; else stay
//     MAC1   1  1  1  acum1<=sum  (a1*fk1+Uk)
//     MAC2   2  2  3  fk<=sum     (a2*fk2+acum1)
//     MAC3   3  3  0  acum2<=sum  (b0*fk)
//     MAC4   4  1  4  acum3<=sum  (b1*fk1+acum2)
//     MAC5   5  2  5  yk<=sum     (b2*fk2+acum3)
//     UPD    0  0  0  fk2<=fk1, fk1<=fk, done=1, ->IDLE
//   - Latency: start accepted at cycle t gives done=1 and the new yk valid at cycle t+6.
//     Throughput: 1 sample per 7 cycles.
//   - start while ready=0 (including the UPD cycle) is ignored, not queued. start held high
//     restarts on every IDLE cycle.
//   - sum is stored verbatim. No width growth, no saturation here; wrap behaviour is the MAC's.
//   - fk/fk1/fk2/yk retain their values between samples. Uk changes only on an accepted start.
//   - controlZ code 2 (yk) is never issued by this sequencer. It is reserved for cascaded sections.
// CONFIGURATION
//   PB200_CLR_EN defined: port clr_state present.
//     - clr_state=1 in IDLE zeroes fk, fk1, fk2, acum1..3 and yk next cycle. It wins over a
//       simultaneous start; the start is not accepted.
//     - clr_state=1 outside IDLE is ignored.
//   PB200_CLR_EN undefined: port absent. History is cleared only by reset.
// STRUCTURE
//   - Select codes (SEL_*), state codes and `N/`F are `define in constantes.h, shared with muxpb200.
//   - Optional sub-module pb200_state_regs: the W-bit register bank with load enables from FSM.
//   - The FSM and select decode stay in this module.
// TESTING  (bench uses a behavioural MAC; `F=14, coeffs a1=32112, a2=-15736, b0=3, b1=6, b2=3)
//   1 reset asserted mid-MAC3 -> next cycle ready=1, all selects 0, all regs 0, no done pulse.
//   2 single start, uk_in=16384 -> selects follow the table exactly in cycles t+1..t+5;
//     acum1=16384, fk=16384, yk=3; done=1 only at t+6; then fk1=16384, fk2=0.
//   3 second start, uk_in=0 -> fk=32112, yk=11; after UPD fk1=32112, fk2=16384.
//   4 start pulsed at t+2 and t+6 of a running sample -> both ignored; exactly one done pulse.
//   5 start held high for 21 cycles -> exactly 3 done pulses, spaced 7 cycles apart.
//   6 (PB200_CLR_EN) clr_state and start together in IDLE -> history regs 0, Uk unchanged,
//     ready stays 1; a following start then reproduces scenario 2.

Source files
------------

// File: rtl/pb200_pkg.sv
// Shared constants for the pb200 IIR section: word format, FSM state codes, mux select codes
// and the register-bank load-enable bundle.
package pb200_pkg;

  localparam int PB200_N = 16;
  localparam int PB200_F = 14;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MAC1 = 3'd1;
  localparam logic [2:0] ST_MAC2 = 3'd2;
  localparam logic [2:0] ST_MAC3 = 3'd3;
  localparam logic [2:0] ST_MAC4 = 3'd4;
  localparam logic [2:0] ST_MAC5 = 3'd5;
  localparam logic [2:0] ST_UPD  = 3'd6;

  localparam logic [2:0] SELS_ZERO = 3'd0;
  localparam logic [2:0] SELS_A1   = 3'd1;
  localparam logic [2:0] SELS_A2   = 3'd2;
  localparam logic [2:0] SELS_B0   = 3'd3;
  localparam logic [2:0] SELS_B1   = 3'd4;
  localparam logic [2:0] SELS_B2   = 3'd5;

  localparam logic [1:0] SELC_ZERO = 2'd0;
  localparam logic [1:0] SELC_FK1  = 2'd1;
  localparam logic [1:0] SELC_FK2  = 2'd2;
  localparam logic [1:0] SELC_FK   = 2'd3;

  localparam logic [2:0] SELZ_ZERO  = 3'd0;
  localparam logic [2:0] SELZ_UK    = 3'd1;
  localparam logic [2:0] SELZ_YK    = 3'd2;
  localparam logic [2:0] SELZ_ACUM1 = 3'd3;
  localparam logic [2:0] SELZ_ACUM2 = 3'd4;
  localparam logic [2:0] SELZ_ACUM3 = 3'd5;

  typedef struct packed {
    logic uk;
    logic acum1;
    logic fk;
    logic acum2;
    logic acum3;
    logic yk;
    logic upd;
    logic clr;
  } pb200_ld_t;

endpackage

// File: rtl/pb200_sequencer_state_regs.sv
// W-bit operand/result register bank of the pb200 section; load enables come from the sequencer FSM.
module pb200_sequencer_state_regs
  import pb200_pkg::*;
#(
  parameter int W = PB200_N
) (
  input  logic         clk,
  input  logic         reset,
  input  pb200_ld_t    ld,
  input  logic [W-1:0] uk_in,
  input  logic [W-1:0] sum,
  output logic [W-1:0] Uk,
  output logic [W-1:0] fk,
  output logic [W-1:0] fk1,
  output logic [W-1:0] fk2,
  output logic [W-1:0] acum1,
  output logic [W-1:0] acum2,
  output logic [W-1:0] acum3,
  output logic [W-1:0] yk
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Uk    <= '0;
      fk    <= '0;
      fk1   <= '0;
      fk2   <= '0;
      acum1 <= '0;
      acum2 <= '0;
      acum3 <= '0;
      yk    <= '0;
    end else begin
      if (ld.uk) Uk <= uk_in;
      // A history clear only happens in IDLE, so it never collides with a MAC write.
      if (ld.clr) begin
        fk    <= '0;
        fk1   <= '0;
        fk2   <= '0;
        acum1 <= '0;
        acum2 <= '0;
        acum3 <= '0;
        yk    <= '0;
      end else begin
        if (ld.acum1) acum1 <= sum;
        if (ld.fk)    fk    <= sum;
        if (ld.acum2) acum2 <= sum;
        if (ld.acum3) acum3 <= sum;
        if (ld.yk)    yk    <= sum;
        if (ld.upd) begin
          fk2 <= fk1;
          fk1 <= fk;
        end
      end
    end
  end

endmodule

// File: rtl/pb200_sequencer.sv
// pb200 2nd-order IIR sequencer: steps the shared MAC through five products per sample.
// Optional macro PB200_CLR_EN adds the clr_state history-clear input.
module pb200_sequencer
  import pb200_pkg::*;
#(
  parameter int W = PB200_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] uk_in,
  input  logic [W-1:0] sum,
`ifdef PB200_CLR_EN
  input  logic         clr_state,
`endif
  output logic         ready,
  output logic         done,
  output logic [2:0]   controlS,
  output logic [1:0]   controlC,
  output logic [2:0]   controlZ,
  output logic [W-1:0] Uk,
  output logic [W-1:0] fk,
  output logic [W-1:0] fk1,
  output logic [W-1:0] fk2,
  output logic [W-1:0] acum1,
  output logic [W-1:0] acum2,
  output logic [W-1:0] acum3,
  output logic [W-1:0] yk
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       clr;
  logic       accept;
  pb200_ld_t  ld;

  assign ready = (state_q == ST_IDLE);
  assign done  = (state_q == ST_UPD);

`ifdef PB200_CLR_EN
  assign clr = clr_state & ready;
`else
  assign clr = 1'b0;
`endif
  // Clear wins over a simultaneous start.
  assign accept = start & ready & ~clr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_MAC1;
      ST_MAC1: state_d = ST_MAC2;
      ST_MAC2: state_d = ST_MAC3;
      ST_MAC3: state_d = ST_MAC4;
      ST_MAC4: state_d = ST_MAC5;
      ST_MAC5: state_d = ST_UPD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    controlS = SELS_ZERO;
    controlC = SELC_ZERO;
    controlZ = SELZ_ZERO;
    case (state_q)
      ST_MAC1: begin controlS = SELS_A1; controlC = SELC_FK1; controlZ = SELZ_UK;    end
      ST_MAC2: begin controlS = SELS_A2; controlC = SELC_FK2; controlZ = SELZ_ACUM1; end
      ST_MAC3: begin controlS = SELS_B0; controlC = SELC_FK;  controlZ = SELZ_ZERO;  end
      ST_MAC4: begin controlS = SELS_B1; controlC = SELC_FK1; controlZ = SELZ_ACUM2; end
      ST_MAC5: begin controlS = SELS_B2; controlC = SELC_FK2; controlZ = SELZ_ACUM3; end
      default: ;
    endcase
  end

  always_comb begin
    ld       = '0;
    ld.uk    = accept;
    ld.clr   = clr;
    ld.acum1 = (state_q == ST_MAC1);
    ld.fk    = (state_q == ST_MAC2);
    ld.acum2 = (state_q == ST_MAC3);
    ld.acum3 = (state_q == ST_MAC4);
    ld.yk    = (state_q == ST_MAC5);
    ld.upd   = (state_q == ST_UPD);
  end

  pb200_sequencer_state_regs #(.W(W)) u_regs (
    .clk   (clk),
    .reset (reset),
    .ld    (ld),
    .uk_in (uk_in),
    .sum   (sum),
    .Uk    (Uk),
    .fk    (fk),
    .fk1   (fk1),
    .fk2   (fk2),
    .acum1 (acum1),
    .acum2 (acum2),
    .acum3 (acum3),
    .yk    (yk)
  );

endmodule

// File: tb/tb_pb200_sequencer.sv
// Directed bench for pb200_sequencer with a behavioural pb200 mux + MAC (F=14).
module tb_pb200_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] uk_in = '0;
  logic [W-1:0] sum;
  logic         clr_state = 1'b0;
  logic         ready, done;
  logic [2:0]   controlS;
  logic [1:0]   controlC;
  logic [2:0]   controlZ;
  logic [W-1:0] Uk, fk, fk1, fk2, acum1, acum2, acum3, yk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done = 0;
  int gap = 0;
  int d0;

  always #5 clk = ~clk;

  pb200_sequencer #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .uk_in     (uk_in),
    .sum       (sum),
`ifdef PB200_CLR_EN
    .clr_state (clr_state),
`endif
    .ready     (ready),
    .done      (done),
    .controlS  (controlS),
    .controlC  (controlC),
    .controlZ  (controlZ),
    .Uk        (Uk),
    .fk        (fk),
    .fk1       (fk1),
    .fk2       (fk2),
    .acum1     (acum1),
    .acum2     (acum2),
    .acum3     (acum3),
    .yk        (yk)
  );

  // Behavioural mux and MAC with a1=32112, a2=-15736, b0=3, b1=6, b2=3.
  logic signed [15:0] coef, stv, addv;
  logic signed [31:0] prod, acc;
  always_comb begin
    coef = '0;
    stv  = '0;
    addv = '0;
    case (controlS)
      3'd1: coef = 16'sd32112;
      3'd2: coef = -16'sd15736;
      3'd3: coef = 16'sd3;
      3'd4: coef = 16'sd6;
      3'd5: coef = 16'sd3;
      default: coef = '0;
    endcase
    case (controlC)
      2'd1: stv = $signed(fk1);
      2'd2: stv = $signed(fk2);
      2'd3: stv = $signed(fk);
      default: stv = '0;
    endcase
    case (controlZ)
      3'd1: addv = $signed(Uk);
      3'd2: addv = $signed(yk);
      3'd3: addv = $signed(acum1);
      3'd4: addv = $signed(acum2);
      3'd5: addv = $signed(acum3);
      default: addv = '0;
    endcase
    prod = 32'(coef) * 32'(stv);
    acc  = (prod >>> 14) + 32'(addv);
    sum  = acc[15:0];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) begin
      done_cnt  <= done_cnt + 1;
      gap       <= cyc - last_done;
      last_done <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sel(input string tag, input logic [2:0] s, input logic [1:0] c, input logic [2:0] z);
    chk({tag, "_S"}, 32'(controlS), 32'(s));
    chk({tag, "_C"}, 32'(controlC), 32'(c));
    chk({tag, "_Z"}, 32'(controlZ), 32'(z));
  endtask

  task automatic run_sample(input logic [W-1:0] u);
    start = 1'b1;
    uk_in = u;
    tick();
    start = 1'b0;
    repeat (6) tick();
  endtask

  // Checks one sample from a zero history with uk_in=16384.
  task automatic sample_16384(input string tag);
    start = 1'b1;
    uk_in = 16'd16384;
    tick();
    start = 1'b0;
    sel({tag, "_mac1"}, 3'd1, 2'd1, 3'd1);
    tick();
    sel({tag, "_mac2"}, 3'd2, 2'd2, 3'd3);
    chk({tag, "_acum1"}, 32'(acum1), 32'd16384);
    tick();
    sel({tag, "_mac3"}, 3'd3, 2'd3, 3'd0);
    chk({tag, "_fk"}, 32'(fk), 32'd16384);
    tick();
    sel({tag, "_mac4"}, 3'd4, 2'd1, 3'd4);
    tick();
    sel({tag, "_mac5"}, 3'd5, 2'd2, 3'd5);
    chk({tag, "_done_t5"}, 32'(done), 32'd0);
    tick();
    chk({tag, "_done_t6"}, 32'(done), 32'd1);
    chk({tag, "_yk"}, 32'(yk), 32'd3);
    sel({tag, "_upd"}, 3'd0, 2'd0, 3'd0);
    tick();
    chk({tag, "_done_t7"}, 32'(done), 32'd0);
    chk({tag, "_fk1"}, 32'(fk1), 32'd16384);
    chk({tag, "_fk2"}, 32'(fk2), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    sel("rst", 3'd0, 2'd0, 3'd0);
    chk("rst_yk", 32'(yk), 32'd0);

    // 1: reset in MAC3 aborts the sample
    start = 1'b1;
    uk_in = 16'd16384;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("s1_in_mac3", 32'(controlS), 32'd3);
    d0 = done_cnt;
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s1_ready", 32'(ready), 32'd1);
    sel("s1", 3'd0, 2'd0, 3'd0);
    chk("s1_acum1", 32'(acum1), 32'd0);
    chk("s1_fk", 32'(fk), 32'd0);
    chk("s1_Uk", 32'(Uk), 32'd0);
    repeat (8) tick();
    chk("s1_no_done", 32'(done_cnt), 32'(d0));

    // 2: first sample
    sample_16384("s2");

    // 3: second sample, uk_in=0
    start = 1'b1;
    uk_in = 16'd0;
    tick();
    start = 1'b0;
    tick();
    chk("s3_acum1", 32'(acum1), 32'd32112);
    tick();
    chk("s3_fk", 32'(fk), 32'd32112);
    repeat (3) tick();
    chk("s3_done", 32'(done), 32'd1);
    chk("s3_yk", 32'(yk), 32'd11);
    tick();
    chk("s3_fk1", 32'(fk1), 32'd32112);
    chk("s3_fk2", 32'(fk2), 32'd16384);

    // 4: starts at t+2 and t+6 are ignored
    d0 = done_cnt;
    start = 1'b1;
    uk_in = 16'd0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    uk_in = 16'd12345;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("s4_upd", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s4_idle_S", 32'(controlS), 32'd0);
    chk("s4_ready", 32'(ready), 32'd1);
    chk("s4_Uk", 32'(Uk), 32'd0);
    repeat (3) tick();
    chk("s4_one_done", 32'(done_cnt - d0), 32'd1);

    // 5: start held for 21 cycles
    d0 = done_cnt;
    start = 1'b1;
    uk_in = 16'd0;
    repeat (21) tick();
    start = 1'b0;
    repeat (8) tick();
    chk("s5_three_done", 32'(done_cnt - d0), 32'd3);
    chk("s5_gap", 32'(gap), 32'd7);

`ifdef PB200_CLR_EN
    // 6: clear wins over start in IDLE
    run_sample(16'd100);
    clr_state = 1'b1;
    start = 1'b1;
    uk_in = 16'd777;
    tick();
    clr_state = 1'b0;
    start = 1'b0;
    chk("s6_ready", 32'(ready), 32'd1);
    chk("s6_Uk", 32'(Uk), 32'd100);
    chk("s6_fk", 32'(fk), 32'd0);
    chk("s6_fk1", 32'(fk1), 32'd0);
    chk("s6_fk2", 32'(fk2), 32'd0);
    chk("s6_acum", 32'(acum1 | acum2 | acum3), 32'd0);
    chk("s6_yk", 32'(yk), 32'd0);
    sample_16384("s6");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
